colour_input_decoder: RTL and testbench

//   Parametrised successor to the purely combinational colour encoder. Synchronises,

---
 rtl/colour_pkg.sv | 19 +
 rtl/colour_debounce.sv | 40 ++++
 rtl/colour_input_decoder.sv | 85 ++++++++
 tb/tb_colour_input_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/colour_pkg.sv
// Shared types for the colour push-button decoder.
// Colour codes and the two-state press FSM.
package colour_pkg;

    localparam int NUM_COLOURS_DEF = 4;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_RED    = 2'd0;
    localparam colour_t COL_BLUE   = 2'd1;
    localparam colour_t COL_YELLOW = 2'd2;
    localparam colour_t COL_GREEN  = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_HELD
    } state_t;

endpackage

// File: rtl/colour_debounce.sv
// One button channel: two-flop synchroniser followed by a
// stability counter that only accepts long-lived level changes.
import colour_pkg::*;

module colour_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db
);

    logic [1:0]       sync;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;

    assign btn_sync = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            // Any return to the accepted level restarts the count
            if (btn_sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= btn_sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/colour_input_decoder.sv
// Debounced colour button decoder: one event per press episode,
// single presses give a code, simultaneous presses give multi_err.
import colour_pkg::*;

module colour_input_decoder #(
    parameter int NUM_COLOURS     = NUM_COLOURS_DEF,
    parameter int CODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_COLOURS-1:0] btn_raw,
    input  logic                   en,
    output logic                   colour_valid,
    output logic [CODE_W-1:0]      colour_code,
    output logic                   multi_err,
    output logic                   any_held
);

    logic [NUM_COLOURS-1:0] db;
    logic [CODE_W-1:0]      idx;
    logic                   one_hot;
    state_t                 state;

    for (genvar i = 0; i < NUM_COLOURS; i++) begin : g_ch
        colour_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .db     (db[i])
        );
    end

    assign one_hot = (db != '0) &&
                     ((db & (db - 1'b1)) == '0);

    // OR of set indices; only meaningful when one_hot
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_COLOURS; i++) begin
            if (db[i]) begin
                idx = idx | CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            colour_valid <= 1'b0;
            colour_code  <= '0;
            multi_err    <= 1'b0;
            any_held     <= 1'b0;
        end else begin
            colour_valid <= 1'b0;
            multi_err    <= 1'b0;
            any_held     <= |db;
            unique case (state)
                S_IDLE: begin
                    if (db != '0) begin
                        state <= S_HELD;
                        if (en) begin
                            if (one_hot) begin
                                colour_valid <= 1'b1;
                                colour_code  <= idx;
                            end else begin
                                multi_err <= 1'b1;
                            end
                        end
                    end
                end
                S_HELD: begin
                    if (db == '0) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_colour_input_decoder.sv
// Scoreboard bench for colour_input_decoder with a short debounce.
// Stimulus queues expected events; a monitor pops and compares.
module tb_colour_input_decoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       en;
    logic       colour_valid;
    logic [1:0] colour_code;
    logic       multi_err;
    logic       any_held;

    typedef struct {
        logic       kind;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_evt = 1'b0;

    colour_input_decoder #(
        .NUM_COLOURS    (4),
        .CODE_W         (2),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .en          (en),
        .colour_valid(colour_valid),
        .colour_code (colour_code),
        .multi_err   (multi_err),
        .any_held    (any_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input int act,
                         input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Expected event: first sampling edge is next edge, pulse D+2 edges later
    task automatic expect_evt(input logic kind,
                              input logic [1:0] code);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.cyc  = cyc + D + 3;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (colour_valid || multi_err) begin
            exp_t e;
            check("exclusive", int'(colour_valid & multi_err), 0);
            check("back_to_back", int'(prev_evt), 0);
            if (q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = q.pop_front();
                check("evt_kind", int'(multi_err), int'(e.kind));
                check("evt_code", int'(colour_code), int'(e.code));
                check("evt_cycle", cyc, e.cyc);
            end
        end
        prev_evt <= colour_valid | multi_err;
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        btn_raw = 4'b0100;

        // 1: reset with yellow held, then single press
        wait_cyc(3);
        check("rst_valid", int'(colour_valid), 0);
        check("rst_code", int'(colour_code), 0);
        check("rst_multi", int'(multi_err), 0);
        check("rst_held", int'(any_held), 0);
        rst = 1'b0;
        expect_evt(1'b0, 2'd2);
        wait_cyc(D + 6);
        check("t1_held", int'(any_held), 1);
        wait_cyc(20);
        check("t1_code", int'(colour_code), 2);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);
        check("t1_release", int'(any_held), 0);

        // 2: short glitch rejected
        btn_raw = 4'b0001;
        wait_cyc(3);
        btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            check("t2_glitch_held", int'(any_held), 0);
        end

        // 3: simultaneous two-button press
        btn_raw = 4'b1010;
        expect_evt(1'b1, 2'd2);
        wait_cyc(D + 6);
        check("t3_held", int'(any_held), 1);
        check("t3_code", int'(colour_code), 2);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);

        // 4: added button during HELD is ignored
        btn_raw = 4'b0010;
        expect_evt(1'b0, 2'd1);
        wait_cyc(D + 6);
        btn_raw = 4'b1010;
        wait_cyc(D + 6);
        check("t4_code_blue", int'(colour_code), 1);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);
        btn_raw = 4'b1000;
        expect_evt(1'b0, 2'd3);
        wait_cyc(D + 6);
        check("t4_code_green", int'(colour_code), 3);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);

        // 5: press swallowed while disabled
        en      = 1'b0;
        btn_raw = 4'b1000;
        wait_cyc(D + 6);
        check("t5_held", int'(any_held), 1);
        en = 1'b1;
        wait_cyc(10);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);
        btn_raw = 4'b0010;
        expect_evt(1'b0, 2'd1);
        wait_cyc(D + 6);
        check("t5_code", int'(colour_code), 1);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);

        // 6: reset in the middle of debounce
        btn_raw = 4'b0100;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        check("t6_rst_code", int'(colour_code), 0);
        check("t6_rst_held", int'(any_held), 0);
        wait_cyc(1);
        rst = 1'b0;
        expect_evt(1'b0, 2'd2);
        wait_cyc(D + 6);
        check("t6_code", int'(colour_code), 2);
        btn_raw = 4'b0000;
        wait_cyc(D + 6);

        check("missing_events", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
